// File: rtl/regvm_pkg.sv
// rtl/regvm_pkg.sv - shared opcodes, instruction layout and FSM states for the register-machine core.
package regvm_pkg;

  typedef enum logic [2:0] {
    OP_AND      = 3'b000,
    OP_OR       = 3'b001,
    OP_XOR      = 3'b010,
    OP_LNOT     = 3'b011,
    OP_MOV      = 3'b100,
    OP_ADD      = 3'b101,
    OP_NOP      = 3'b110,
    OP_NOP_ALT  = 3'b111
  } op_e;

  localparam int OP_W      = 3;
  localparam int DEF_NREGS = 4;
  localparam int DEF_DST_W = $clog2(DEF_NREGS);
  localparam int DEF_SRC_W = $clog2(2 * DEF_NREGS);
  localparam int DEF_IW    = OP_W + DEF_DST_W + DEF_SRC_W;

  typedef struct packed {
    op_e                  op;
    logic [DEF_DST_W-1:0] dst;
    logic [DEF_SRC_W-1:0] src;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXEC   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/regvm_seq_core_if.sv
// rtl/regvm_seq_core_if.sv - program-load and run/result port bundle of regvm_seq_core.
interface regvm_seq_core_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int DEPTH = 64
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = 3 + $clog2(NREGS) + $clog2(2 * NREGS);

  logic                   prog_we;
  logic [AW-1:0]          prog_addr;
  logic [IW-1:0]          prog_wdata;
  logic [LW-1:0]          prog_len;
  logic                   start;
  logic [NREGS*WIDTH-1:0] in_vec;
  logic                   busy;
  logic                   done;
  logic [NREGS*WIDTH-1:0] y_vec;

  modport master (
    output prog_we, prog_addr, prog_wdata, prog_len, start, in_vec,
    input  busy, done, y_vec
  );

  modport slave (
    input  prog_we, prog_addr, prog_wdata, prog_len, start, in_vec,
    output busy, done, y_vec
  );
endinterface

// File: rtl/regvm_alu.sv
// rtl/regvm_alu.sv - combinational op unit; REGVM_ADD_EN enables the modular ADD op (else 101 is NOP).
module regvm_alu
  import regvm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] dst_val,
  input  logic [WIDTH-1:0] src_val,
  output logic [WIDTH-1:0] result
);

  always_comb begin
    result = dst_val;
    case (op)
      OP_AND:  result = dst_val & src_val;
      OP_OR:   result = dst_val | src_val;
      OP_XOR:  result = dst_val ^ src_val;
      OP_LNOT: result = WIDTH'(~|src_val);
      OP_MOV:  result = src_val;
`ifdef REGVM_ADD_EN
      OP_ADD:  result = dst_val + src_val;
`else
      OP_ADD:  result = dst_val;
`endif
      default: result = dst_val;
    endcase
  end

endmodule

// File: rtl/regvm_seq_core.sv
// rtl/regvm_seq_core.sv - one-instruction-per-clock register-machine interpreter with loadable program RAM.
// Op 101 behaviour depends on REGVM_ADD_EN (see regvm_alu).
module regvm_seq_core
  import regvm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 4,
  parameter int DEPTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  regvm_seq_core_if.slave  bus
);
  localparam int DW = $clog2(NREGS);
  localparam int SW = $clog2(2 * NREGS);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);
  localparam int IW = OP_W + DW + SW;

  logic [IW-1:0]          mem [DEPTH];
  state_e                 state, state_nxt;
  logic [AW-1:0]          pc;
  logic [LW-1:0]          len_q, len_clamped;
  logic [WIDTH-1:0]       regs [NREGS];
  logic [WIDTH-1:0]       snap [NREGS];
  logic [NREGS*WIDTH-1:0] y_q;
  logic                   busy_q, done_q;
  logic [IW-1:0]          instr;
  op_e                    op;
  logic [DW-1:0]          dst;
  logic [SW-1:0]          src;
  logic [WIDTH-1:0]       dst_val, src_val, alu_res;
  logic                   accept, last;

  assign accept      = (state == ST_IDLE) && bus.start;
  assign len_clamped = (bus.prog_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.prog_len;

  assign instr   = mem[pc];
  assign op      = op_e'(instr[IW-1 -: OP_W]);
  assign dst     = instr[SW +: DW];
  assign src     = instr[SW-1:0];
  assign dst_val = regs[dst];
  // Upper half of the source space addresses the input snapshot, not live registers.
  assign src_val = src[SW-1] ? snap[src[DW-1:0]] : regs[src[DW-1:0]];
  assign last    = (LW'(pc) == len_q - LW'(1));

  regvm_alu #(.WIDTH(WIDTH)) u_alu (
    .op      (op),
    .dst_val (dst_val),
    .src_val (src_val),
    .result  (alu_res)
  );

  // Program RAM is deliberately outside reset so a loaded individual survives it.
  always_ff @(posedge clk) begin
    if (bus.prog_we && state == ST_IDLE)
      mem[bus.prog_addr] <= bus.prog_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (bus.start) state_nxt = (len_clamped == '0) ? ST_FINISH : ST_EXEC;
      ST_EXEC:   if (last) state_nxt = ST_FINISH;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc     <= '0;
      len_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      y_q    <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
        snap[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            for (int i = 0; i < NREGS; i++) begin
              regs[i] <= bus.in_vec[i*WIDTH +: WIDTH];
              snap[i] <= bus.in_vec[i*WIDTH +: WIDTH];
            end
            pc     <= '0;
            len_q  <= len_clamped;
            busy_q <= 1'b1;
          end
        end
        ST_EXEC: begin
          regs[dst] <= alu_res;
          if (!last) pc <= pc + 1'b1;
        end
        ST_FINISH: begin
          for (int i = 0; i < NREGS; i++)
            y_q[i*WIDTH +: WIDTH] <= regs[i];
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.y_vec = y_q;

endmodule

// File: tb/tb_regvm_seq_core.sv
// tb/tb_regvm_seq_core.sv - directed self-checking bench for regvm_seq_core (NREGS=4, WIDTH=16, DEPTH=64).
module tb_regvm_seq_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  regvm_seq_core_if #(.WIDTH(16), .NREGS(4), .DEPTH(64)) bus ();

  regvm_seq_core #(.WIDTH(16), .NREGS(4), .DEPTH(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [7:0] enc(input logic [2:0] op, input logic [1:0] dst, input logic [2:0] src);
    return {op, dst, src};
  endfunction

  function automatic logic [63:0] pack4(input logic [15:0] a0, a1, a2, a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic load(input int addr, input logic [7:0] w);
    @(negedge clk);
    bus.prog_we    = 1'b1;
    bus.prog_addr  = 6'(addr);
    bus.prog_wdata = w;
    @(posedge clk);
    #1 bus.prog_we = 1'b0;
  endtask

  task automatic wait_done(inout int lat);
    while (bus.done !== 1'b1 && lat < 300) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  // Returns edges counted after the accepting edge until done is seen.
  task automatic do_run(input logic [6:0] len, input logic [63:0] iv, output int lat, output logic [63:0] y);
    @(negedge clk);
    bus.prog_len = len;
    bus.in_vec   = iv;
    bus.start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    wait_done(lat);
    y = bus.y_vec;
  endtask

  task automatic test_reset();
    int lat; logic [63:0] y;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y_vec !== 64'h0) begin
      bad++; $display("FAIL reset_init busy=%b done=%b y=%h exp 0/0/0", bus.busy, bus.done, bus.y_vec); end
    rst = 1'b0;
    load(0, enc(3'b000, 2'd0, 3'd5));
    do_run(7'd0, pack4(16'h1, 16'h2, 16'h3, 16'h4), lat, y);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y_vec !== 64'h0) begin
      bad++; $display("FAIL reset_idle busy=%b done=%b y=%h exp 0/0/0", bus.busy, bus.done, bus.y_vec); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_and();
    int lat; logic [63:0] y;
    do_run(7'd1, pack4(16'h00FF, 16'h0F0F, 16'h1234, 16'hABCD), lat, y);
    total++; if (lat !== 2) begin bad++; $display("FAIL and_latency got=%0d exp=2", lat); end
    total++; if (y !== pack4(16'h000F, 16'h0F0F, 16'h1234, 16'hABCD)) begin
      bad++; $display("FAIL and_result got=%h exp=%h", y, pack4(16'h000F, 16'h0F0F, 16'h1234, 16'hABCD)); end
    @(negedge clk);
    total++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      bad++; $display("FAIL and_done_pulse done=%b busy=%b exp 0/0", bus.done, bus.busy); end
  endtask

  task automatic test_lnot_xor_or();
    int lat; logic [63:0] y;
    load(0, enc(3'b011, 2'd3, 3'd4));
    load(1, enc(3'b010, 2'd2, 3'd2));
    load(2, enc(3'b001, 2'd1, 3'd3));
    do_run(7'd3, pack4(16'h0000, 16'h0100, 16'h5555, 16'h7777), lat, y);
    total++; if (lat !== 4) begin bad++; $display("FAIL seq_latency got=%0d exp=4", lat); end
    total++; if (y !== pack4(16'h0000, 16'h0101, 16'h0000, 16'h0001)) begin
      bad++; $display("FAIL seq_run1 got=%h exp=%h", y, pack4(16'h0000, 16'h0101, 16'h0000, 16'h0001)); end
    do_run(7'd3, pack4(16'h8000, 16'h0100, 16'h5555, 16'h7777), lat, y);
    total++; if (y !== pack4(16'h8000, 16'h0100, 16'h0000, 16'h0000)) begin
      bad++; $display("FAIL seq_run2 got=%h exp=%h", y, pack4(16'h8000, 16'h0100, 16'h0000, 16'h0000)); end
  endtask

  task automatic test_len_bounds();
    int lat; logic [63:0] y;
    do_run(7'd0, pack4(16'hCAFE, 16'hBEEF, 16'h0123, 16'h4567), lat, y);
    total++; if (lat !== 1) begin bad++; $display("FAIL len0_latency got=%0d exp=1", lat); end
    total++; if (y !== pack4(16'hCAFE, 16'hBEEF, 16'h0123, 16'h4567)) begin
      bad++; $display("FAIL len0_result got=%h exp=%h", y, pack4(16'hCAFE, 16'hBEEF, 16'h0123, 16'h4567)); end
    for (int a = 0; a < 64; a++) load(a, enc(3'b100, 2'd0, 3'd1));
    do_run(7'd64, pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444), lat, y);
    total++; if (lat !== 65) begin bad++; $display("FAIL len64_latency got=%0d exp=65", lat); end
    total++; if (y !== pack4(16'h2222, 16'h2222, 16'h3333, 16'h4444)) begin
      bad++; $display("FAIL len64_result got=%h exp=%h", y, pack4(16'h2222, 16'h2222, 16'h3333, 16'h4444)); end
    do_run(7'd100, pack4(16'h1111, 16'h2222, 16'h3333, 16'h4444), lat, y);
    total++; if (lat !== 65) begin bad++; $display("FAIL len_clamp_latency got=%0d exp=65", lat); end
  endtask

  task automatic test_ignore_during_run();
    int lat; int extra; logic [63:0] y;
    logic [63:0] iv, ex;
    iv = pack4(16'h1234, 16'h00FF, 16'h0FF0, 16'hF0F0);
    ex = pack4(16'h12CB, 16'h00FF, 16'h1FFB, 16'h00F0);
    load(0, enc(3'b010, 2'd0, 3'd5));
    load(1, enc(3'b001, 2'd2, 3'd0));
    load(2, enc(3'b000, 2'd3, 3'd6));
    @(negedge clk);
    bus.prog_len = 7'd3; bus.in_vec = iv; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL busy_in_run got=%b exp=1", bus.busy); end
    bus.in_vec = 64'hFFFF_FFFF_FFFF_FFFF;
    bus.prog_we = 1'b1; bus.prog_addr = 6'd0; bus.prog_wdata = enc(3'b110, 2'd0, 3'd0);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.prog_we = 1'b0;
    lat = 1;
    wait_done(lat);
    y = bus.y_vec;
    total++; if (lat !== 4) begin bad++; $display("FAIL ignore_latency got=%0d exp=4", lat); end
    total++; if (y !== ex) begin bad++; $display("FAIL ignore_result got=%h exp=%h", y, ex); end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) extra++;
    end
    total++; if (extra !== 0) begin bad++; $display("FAIL no_queued_run got=%0d exp=0", extra); end
    do_run(7'd3, iv, lat, y);
    total++; if (y !== ex) begin bad++; $display("FAIL mem_unchanged got=%h exp=%h", y, ex); end
  endtask

  task automatic test_reset_in_exec();
    int lat; int seen; logic [63:0] y, iv, ex;
    iv = pack4(16'h1234, 16'h00FF, 16'h0FF0, 16'hF0F0);
    ex = pack4(16'h12CB, 16'h00FF, 16'h1FFB, 16'h00F0);
    @(negedge clk);
    bus.prog_len = 7'd3; bus.in_vec = iv; bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.y_vec !== 64'h0) begin
      bad++; $display("FAIL rst_exec busy=%b done=%b y=%h exp 0/0/0", bus.busy, bus.done, bus.y_vec); end
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 1) rst = 1'b0;
      if (bus.done !== 1'b0) seen++;
    end
    total++; if (seen !== 0) begin bad++; $display("FAIL rst_no_done got=%0d exp=0", seen); end
    do_run(7'd3, iv, lat, y);
    total++; if (y !== ex) begin bad++; $display("FAIL rst_rerun got=%h exp=%h", y, ex); end
  endtask

  task automatic test_add();
    int lat; logic [63:0] y;
    logic [15:0] e_wrap, e_plain;
`ifdef REGVM_ADD_EN
    e_wrap = 16'h0000; e_plain = 16'h1235;
`else
    e_wrap = 16'hFFFF; e_plain = 16'h1234;
`endif
    load(0, enc(3'b101, 2'd0, 3'd5));
    do_run(7'd1, pack4(16'hFFFF, 16'h0001, 16'h0000, 16'h0000), lat, y);
    total++; if (y[15:0] !== e_wrap) begin bad++; $display("FAIL add_wrap got=%h exp=%h", y[15:0], e_wrap); end
    do_run(7'd1, pack4(16'h1234, 16'h0001, 16'h0000, 16'h0000), lat, y);
    total++; if (y[15:0] !== e_plain) begin bad++; $display("FAIL add_plain got=%h exp=%h", y[15:0], e_plain); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [63:0] y, ex;
    load(0, enc(3'b100, 2'd1, 3'd4));
    do_run(7'd1, pack4(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD), lat, y);
    total++; if (y !== pack4(16'hAAAA, 16'hAAAA, 16'hCCCC, 16'hDDDD)) begin
      bad++; $display("FAIL b2b_first got=%h exp=%h", y, pack4(16'hAAAA, 16'hAAAA, 16'hCCCC, 16'hDDDD)); end
    // Restart on the done cycle, rewriting instruction 0 on the same accepting edge.
    bus.in_vec = pack4(16'h0101, 16'h0202, 16'h0303, 16'h0404);
    bus.start = 1'b1;
    bus.prog_we = 1'b1; bus.prog_addr = 6'd0; bus.prog_wdata = enc(3'b010, 2'd1, 3'd4);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0; bus.prog_we = 1'b0;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL b2b_accept busy=%b exp=1", bus.busy); end
    lat = 0;
    wait_done(lat);
    ex = pack4(16'h0101, 16'h0303, 16'h0303, 16'h0404);
    total++; if (lat !== 2) begin bad++; $display("FAIL b2b_latency got=%0d exp=2", lat); end
    total++; if (bus.y_vec !== ex) begin bad++; $display("FAIL b2b_second got=%h exp=%h", bus.y_vec, ex); end
  endtask

  initial begin
    bus.prog_we = 1'b0; bus.prog_addr = '0; bus.prog_wdata = '0;
    bus.prog_len = '0; bus.start = 1'b0; bus.in_vec = '0;
    test_reset();
    test_and();
    test_lnot_xor_or();
    test_len_bounds();
    test_ignore_during_run();
    test_reset_in_exec();
    test_add();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
